// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request feeding a 2-entry
// {pc, ins} buffer, with redirect squash handling for in-flight requests.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  input  logic        DEC_READY,
  output logic        MEM_READ,
  output logic [31:0] MEM_ADDRESS,
  input  logic        MEM_BUSYWAIT,
  input  logic [31:0] MEM_READDATA,
  output logic        INS_VALID,
  output logic [31:0] INS,
  output logic [31:0] INS_PC
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StSquash
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_read_q, mem_read_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] head_ins_q, head_ins_d;
  logic [31:0] tail_pc_q, tail_pc_d;
  logic [31:0] tail_ins_q, tail_ins_d;

  logic        completion;
  logic        push;
  logic        pop;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc_inc;
  logic        unused_redirect_pc_lsbs;

  assign completion   = mem_read_q & ~MEM_BUSYWAIT;
  assign push         = completion & (state_q == StFetch);
  assign pop          = (count_q != 2'd0) & DEC_READY;
  assign redirect_pc  = {REDIRECT_PC[31:2], 2'b00};
  // Natural 32-bit overflow gives the FFFF_FFFC -> 0000_0000 wrap.
  assign fetch_pc_inc = fetch_pc_q + 32'd4;

  assign unused_redirect_pc_lsbs = ^REDIRECT_PC[1:0];

  // Fetch buffer: head slot drives the outputs, tail slot holds the second entry.
  always_comb begin
    count_d    = count_q;
    head_pc_d  = head_pc_q;
    head_ins_d = head_ins_q;
    tail_pc_d  = tail_pc_q;
    tail_ins_d = tail_ins_q;
    if (REDIRECT) begin
      // Zero the head so nothing fetched before the redirect is ever visible on INS.
      count_d    = 2'd0;
      head_pc_d  = 32'd0;
      head_ins_d = 32'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_pc_d  = mem_addr_q;
            head_ins_d = MEM_READDATA;
          end else begin
            tail_pc_d  = mem_addr_q;
            tail_ins_d = MEM_READDATA;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          // Popping the last entry leaves the head holding its old values.
          if (count_q == 2'd2) begin
            head_pc_d  = tail_pc_q;
            head_ins_d = tail_ins_q;
          end
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_pc_d  = mem_addr_q;
            head_ins_d = MEM_READDATA;
          end else begin
            head_pc_d  = tail_pc_q;
            head_ins_d = tail_ins_q;
            tail_pc_d  = mem_addr_q;
            tail_ins_d = MEM_READDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Request FSM; count_d is the post-edge occupancy used for the refetch decision.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    unique case (state_q)
      StIdle: begin
        if (REDIRECT) begin
          fetch_pc_d = redirect_pc;
          mem_addr_d = redirect_pc;
          state_d    = StFetch;
        end else if (count_d < 2'd2) begin
          mem_addr_d = fetch_pc_q;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        if (REDIRECT) begin
          fetch_pc_d = redirect_pc;
          if (completion) begin
            mem_addr_d = redirect_pc;
            state_d    = StFetch;
          end else begin
            state_d = StSquash;
          end
        end else if (completion) begin
          fetch_pc_d = fetch_pc_inc;
          if (count_d < 2'd2) begin
            mem_addr_d = fetch_pc_inc;
            state_d    = StFetch;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StSquash: begin
        if (REDIRECT) begin
          fetch_pc_d = redirect_pc;
        end
        if (completion) begin
          mem_addr_d = fetch_pc_d;
          state_d    = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_read_d = (state_d != StIdle);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= 32'd0;
      mem_read_q <= 1'b0;
      count_q    <= 2'd0;
      head_pc_q  <= 32'd0;
      head_ins_q <= 32'd0;
      tail_pc_q  <= 32'd0;
      tail_ins_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_read_q <= mem_read_d;
      count_q    <= count_d;
      head_pc_q  <= head_pc_d;
      head_ins_q <= head_ins_d;
      tail_pc_q  <= tail_pc_d;
      tail_ins_q <= tail_ins_d;
    end
  end

  assign MEM_READ    = mem_read_q;
  assign MEM_ADDRESS = mem_addr_q;
  assign INS_VALID   = (count_q != 2'd0);
  assign INS         = head_ins_q;
  assign INS_PC      = head_pc_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: cycle table of inputs/expected outputs,
// an accepted-instruction scoreboard, and a hand-written mid-request reset sequence.
module tb_imem_fetch_ctrl;

  logic        CLK;
  logic        RESET;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        DEC_READY;
  logic        MEM_READ;
  logic [31:0] MEM_ADDRESS;
  logic        MEM_BUSYWAIT;
  logic [31:0] MEM_READDATA;
  logic        INS_VALID;
  logic [31:0] INS;
  logic [31:0] INS_PC;

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .REDIRECT     (REDIRECT),
    .REDIRECT_PC  (REDIRECT_PC),
    .DEC_READY    (DEC_READY),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .MEM_READDATA (MEM_READDATA),
    .INS_VALID    (INS_VALID),
    .INS          (INS),
    .INS_PC       (INS_PC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h1357_9BDF;
  endfunction

  // Memory model: word is a fixed hash of the requested address.
  assign MEM_READDATA = word_of(MEM_ADDRESS);

  typedef struct {
    logic        redirect;
    logic [31:0] rpc;
    logic        dr;
    logic        bw;
    logic        e_mr;
    logic [31:0] e_addr;
    logic        e_v;
    logic        chk_pc;
    logic [31:0] e_pc;
  } row_t;

  row_t        tbl[$];
  logic [31:0] sb_q[$];
  int          tests  = 0;
  int          failed = 0;
  logic        prev_v;
  logic [31:0] prev_pc;

  function automatic row_t mk(input logic rd, input logic [31:0] rpc, input logic dr,
                              input logic bw, input logic mr, input logic [31:0] addr,
                              input logic v, input logic chk, input logic [31:0] pc);
    row_t r;
    r.redirect = rd;  r.rpc = rpc;   r.dr = dr;  r.bw = bw;
    r.e_mr = mr;      r.e_addr = addr; r.e_v = v; r.chk_pc = chk; r.e_pc = pc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive, check pops just before the edge, then check outputs.
  task automatic do_row(input row_t r, input int idx);
    string tag;
    logic [31:0] exp_pc;
    tag = $sformatf("row%0d", idx);
    REDIRECT     = r.redirect;
    REDIRECT_PC  = r.rpc;
    DEC_READY    = r.dr;
    MEM_BUSYWAIT = r.bw;
    if (r.dr && prev_v && !r.redirect) sb_q.push_back(prev_pc);
    #4;
    if (INS_VALID && DEC_READY && !REDIRECT) begin
      if (sb_q.size() == 0) begin
        chk({tag, "_unexpected_pop"}, 32'd1, 32'd0);
      end else begin
        exp_pc = sb_q.pop_front();
        chk({tag, "_pop_pc"}, INS_PC, exp_pc);
        chk({tag, "_pop_ins"}, INS, word_of(exp_pc));
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    chk({tag, "_mem_read"}, {31'd0, MEM_READ}, {31'd0, r.e_mr});
    chk({tag, "_mem_addr"}, MEM_ADDRESS, r.e_addr);
    chk({tag, "_ins_valid"}, {31'd0, INS_VALID}, {31'd0, r.e_v});
    if (r.chk_pc) begin
      chk({tag, "_ins_pc"}, INS_PC, r.e_pc);
      chk({tag, "_ins"}, INS, word_of(r.e_pc));
    end
    prev_v  = r.e_v;
    prev_pc = r.e_pc;
  endtask

  initial begin
    // redirect, rpc, dec_ready, busywait | mem_read, addr, valid, check_pc, pc
    // Streaming at one per cycle from RESET_PC.
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h0,   0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h4,   1, 1, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h8,   1, 1, 32'h4));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'hC,   1, 1, 32'h8));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h10,  1, 1, 32'hC));
    // Redirect to 0 on a completing edge, then decode stalled: buffer fills and idles.
    tbl.push_back(mk(1, 32'h0, 0, 0, 1, 32'h0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h4,   1, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h4,   1, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h4,   1, 1, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h8,   1, 1, 32'h4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h8,   1, 1, 32'h4));
    // Busywait for three cycles: address held, single push on completion.
    tbl.push_back(mk(0, 0, 1, 1, 1, 32'hC,   1, 1, 32'h8));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'hC,   1, 1, 32'h8));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'hC,   1, 1, 32'h8));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'hC,   1, 1, 32'h8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'hC,   1, 1, 32'h8));
    tbl.push_back(mk(0, 0, 1, 1, 1, 32'h10,  1, 1, 32'hC));
    tbl.push_back(mk(0, 0, 1, 1, 1, 32'h10,  0, 1, 32'hC));
    // Redirect while busy: squash the in-flight word.
    tbl.push_back(mk(1, 32'h103, 0, 1, 1, 32'h10, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h104, 1, 1, 32'h100));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h108, 1, 1, 32'h104));
    // Redirect to top of memory, then wrap to zero.
    tbl.push_back(mk(1, 32'hFFFF_FFFF, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h0,   1, 1, 32'hFFFF_FFFC));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h4,   1, 1, 32'h0));
    // Two redirects during squash: the last one wins.
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h4,   1, 1, 32'h0));
    tbl.push_back(mk(1, 32'h200, 0, 1, 1, 32'h4, 0, 0, 32'h0));
    tbl.push_back(mk(1, 32'h300, 0, 1, 1, 32'h4, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h300, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 32'h300, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h304, 1, 1, 32'h300));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h304, 1, 1, 32'h300));
    // Redirect while idle with a full buffer; the simultaneous pop is discarded.
    tbl.push_back(mk(1, 32'h400, 1, 0, 1, 32'h400, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h404, 1, 1, 32'h400));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h408, 1, 1, 32'h404));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h408, 1, 1, 32'h404));

    RESET        = 1'b0;
    REDIRECT     = 1'b0;
    REDIRECT_PC  = 32'd0;
    DEC_READY    = 1'b0;
    MEM_BUSYWAIT = 1'b0;
    prev_v       = 1'b0;
    prev_pc      = 32'd0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("rst_mem_addr", MEM_ADDRESS, 32'd0);
    chk("rst_ins_valid", {31'd0, INS_VALID}, 32'd0);
    chk("rst_ins", INS, 32'd0);
    chk("rst_ins_pc", INS_PC, 32'd0);
    RESET = 1'b1;

    foreach (tbl[i]) do_row(tbl[i], i);

    // Reset asserted mid-request: outputs drop before the next edge.
    #2;
    RESET = 1'b0;
    #1;
    chk("arst_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("arst_ins_valid", {31'd0, INS_VALID}, 32'd0);
    chk("arst_mem_addr", MEM_ADDRESS, 32'd0);
    chk("arst_ins", INS, 32'd0);
    chk("arst_ins_pc", INS_PC, 32'd0);
    MEM_BUSYWAIT = 1'b0;
    @(negedge CLK);
    chk("arst_hold_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("arst_hold_ins_valid", {31'd0, INS_VALID}, 32'd0);
    RESET   = 1'b1;
    prev_v  = 1'b0;
    prev_pc = 32'd0;
    do_row(mk(0, 0, 1, 0, 1, 32'h0, 0, 0, 32'h0), 100);
    do_row(mk(0, 0, 1, 0, 1, 32'h4, 1, 1, 32'h0), 101);
    do_row(mk(0, 0, 1, 0, 1, 32'h8, 1, 1, 32'h4), 102);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
